// File: rtl/unroller_pkg.sv
// Shared helpers for the unroller re-packer.
package unroller_pkg;

  // Counter width for a beat counter spanning 0..beats-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/unroller.sv
// unroller: width-expanding re-packer. Gathers BEATS = OUT_NUM/IN_NUM consecutive
// IN_NUM-element input beats into one OUT_NUM-element output word, order-preserving,
// sustaining one input beat per cycle.
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active high
//   data_in         input beat, IN_NUM elements of DATA_WIDTH bits
//   data_in_valid   input beat valid
//   data_in_ready   input beat accepted when valid & ready
//   data_out        assembled word, OUT_NUM elements of DATA_WIDTH bits (registered)
//   data_out_valid  word valid (registered)
//   data_out_ready  downstream accepts when valid & ready
module unroller
  import unroller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_NUM     = 1,
  parameter int unsigned OUT_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int unsigned BEATS = OUT_NUM / IN_NUM;
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  // Output word must be a whole number of input beats.
  if ((IN_NUM == 0) || (OUT_NUM % IN_NUM != 0)) begin : g_bad_ratio
    $error("unroller: OUT_NUM (%0d) must be a non-zero multiple of IN_NUM (%0d)", OUT_NUM, IN_NUM);
  end

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  last_c;
  logic                  accept_c;
  logic                  load_c;
  logic                  out_valid_nxt;
  logic [DATA_WIDTH-1:0] word_c [OUT_NUM];

  assign last_c = (cnt == CNT_LAST);

  // Only the word-completing beat depends on the output side.
  always_comb begin
    data_in_ready = 1'b0;
    if (!rst) begin
      data_in_ready = last_c ? (!data_out_valid || data_out_ready) : 1'b1;
    end
  end

  assign accept_c = data_in_valid & data_in_ready;
  assign load_c   = accept_c & last_c;

  // Beat position within the word being gathered.
  always_comb begin
    cnt_nxt = cnt;
    if (accept_c) begin
      cnt_nxt = last_c ? '0 : CNT_W'(cnt + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  if (BEATS > 1) begin : g_stage
    localparam int unsigned STG_N = (BEATS - 1) * IN_NUM;

    logic [DATA_WIDTH-1:0] staging [STG_N];

    // Beats 0..BEATS-2 park here; beat k occupies slots k*IN_NUM .. k*IN_NUM+IN_NUM-1.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < STG_N; i++) begin
          staging[i] <= '0;
        end
      end else if (accept_c && !last_c) begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (cnt == CNT_W'(k)) begin
            for (int j = 0; j < IN_NUM; j++) begin
              staging[k*IN_NUM + j] <= data_in[j];
            end
          end
        end
      end
    end

    // Completed word: staged beats followed by the live last beat.
    always_comb begin
      for (int i = 0; i < STG_N; i++) begin
        word_c[i] = staging[i];
      end
      for (int j = 0; j < IN_NUM; j++) begin
        word_c[STG_N + j] = data_in[j];
      end
    end
  end else begin : g_pass
    // Single-beat words: plain register slice.
    always_comb begin
      for (int j = 0; j < IN_NUM; j++) begin
        word_c[j] = data_in[j];
      end
    end
  end

  // A load in the same cycle as a drain keeps valid high for back-to-back words.
  always_comb begin
    out_valid_nxt = data_out_valid;
    if (load_c) begin
      out_valid_nxt = 1'b1;
    end else if (data_out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  // Output register; only reloads when the current word is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      for (int i = 0; i < OUT_NUM; i++) begin
        data_out[i] <= '0;
      end
    end else begin
      data_out_valid <= out_valid_nxt;
      if (load_c) begin
        for (int i = 0; i < OUT_NUM; i++) begin
          data_out[i] <= word_c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_unroller.sv
// Self-checking bench for unroller: three configurations (1->4, 2->6, 4->4),
// table-driven directed sequences, hand-written corner cases and a randomized
// run against an element-queue reference model.
module tb_unroller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: IN_NUM=1, OUT_NUM=4
  logic [7:0] a_din [1];
  logic       a_vin, a_irdy, a_ov, a_ordy;
  logic [7:0] a_dout [4];
  // u1: IN_NUM=2, OUT_NUM=6
  logic [7:0] b_din [2];
  logic       b_vin, b_irdy, b_ov, b_ordy;
  logic [7:0] b_dout [6];
  // u2: IN_NUM=4, OUT_NUM=4
  logic [7:0] c_din [4];
  logic       c_vin, c_irdy, c_ov, c_ordy;
  logic [7:0] c_dout [4];

  unroller #(.DATA_WIDTH(8), .IN_NUM(1), .OUT_NUM(4)) u0 (
    .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_vin), .data_in_ready(a_irdy),
    .data_out(a_dout), .data_out_valid(a_ov), .data_out_ready(a_ordy));
  unroller #(.DATA_WIDTH(8), .IN_NUM(2), .OUT_NUM(6)) u1 (
    .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_vin), .data_in_ready(b_irdy),
    .data_out(b_dout), .data_out_valid(b_ov), .data_out_ready(b_ordy));
  unroller #(.DATA_WIDTH(8), .IN_NUM(4), .OUT_NUM(4)) u2 (
    .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_vin), .data_in_ready(c_irdy),
    .data_out(c_dout), .data_out_valid(c_ov), .data_out_ready(c_ordy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted element is queued; each output handshake
  // must deliver the oldest OUT_NUM elements.
  logic [7:0] q [3][$];
  int         acc_beats [3];
  int         words_out [3];
  logic       hold_v [3];
  logic [7:0] hold_d [3][6];

  task automatic mon(input int id, input int in_num, input int out_num,
                     input logic vin, input logic [7:0] di [4], input logic irdy,
                     input logic ov, input logic [7:0] dx [6], input logic ordy);
    int   beats;
    logic exp_irdy;
    beats = out_num / in_num;
    if (rst) begin
      chk($sformatf("u%0d_ready_in_reset", id), 32'(irdy), 32'd0);
      q[id].delete();
      acc_beats[id] = 0;
      hold_v[id] = 1'b0;
      return;
    end
    exp_irdy = ((acc_beats[id] % beats) != beats - 1) ? 1'b1 : (!ov || ordy);
    chk($sformatf("u%0d_in_ready_rule", id), 32'(irdy), 32'(exp_irdy));
    if (hold_v[id]) begin
      chk($sformatf("u%0d_valid_hold", id), 32'(ov), 32'd1);
      for (int i = 0; i < out_num; i++)
        chk($sformatf("u%0d_data_hold[%0d]", id, i), 32'(dx[i]), 32'(hold_d[id][i]));
    end
    if (ov && ordy) begin
      words_out[id]++;
      chk($sformatf("u%0d_word_has_source", id), 32'(q[id].size() >= out_num), 32'd1);
      if (q[id].size() >= out_num) begin
        for (int i = 0; i < out_num; i++) begin
          logic [7:0] e;
          e = q[id].pop_front();
          chk($sformatf("u%0d_word_data[%0d]", id, i), 32'(dx[i]), 32'(e));
        end
      end else begin
        q[id].delete();
      end
    end
    hold_v[id] = ov && !ordy;
    for (int i = 0; i < 6; i++) hold_d[id][i] = dx[i];
    if (vin && irdy) begin
      for (int j = 0; j < in_num; j++) q[id].push_back(di[j]);
      acc_beats[id]++;
    end
  endtask

  logic [7:0] m_di [4];
  logic [7:0] m_dx [6];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) m_di[i] = '0;
    for (int i = 0; i < 6; i++) m_dx[i] = '0;
    m_di[0] = a_din[0];
    for (int i = 0; i < 4; i++) m_dx[i] = a_dout[i];
    mon(0, 1, 4, a_vin, m_di, a_irdy, a_ov, m_dx, a_ordy);
    for (int i = 0; i < 2; i++) m_di[i] = b_din[i];
    for (int i = 0; i < 6; i++) m_dx[i] = b_dout[i];
    mon(1, 2, 6, b_vin, m_di, b_irdy, b_ov, m_dx, b_ordy);
    for (int i = 0; i < 4; i++) m_di[i] = c_din[i];
    for (int i = 0; i < 4; i++) m_dx[i] = c_dout[i];
    mon(2, 4, 4, c_vin, m_di, c_irdy, c_ov, m_dx, c_ordy);
  end

  // Directed per-cycle vectors for u0: word is {d3,d2,d1,d0}, data_out[i] = byte i.
  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        rdy;
    logic        exp_irdy;
    logic        exp_ov;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic vin, input logic [7:0] din, input logic rdy,
                     input logic exp_irdy, input logic exp_ov, input logic [31:0] exp_word);
    vec_t v;
    v.vin = vin; v.din = din; v.rdy = rdy;
    v.exp_irdy = exp_irdy; v.exp_ov = exp_ov; v.exp_word = exp_word;
    vt.push_back(v);
  endtask

  localparam logic [31:0] W0123 = 32'h03020100;
  localparam logic [31:0] W4567 = 32'h07060504;

  int         tgt [3];
  int         wtgt [3];
  bit         done;
  logic [7:0] prev [4];
  logic [7:0] exp6 [6];

  initial begin
    a_vin = 0; a_din[0] = '0; a_ordy = 1;
    b_vin = 0; b_din[0] = '0; b_din[1] = '0; b_ordy = 1;
    c_vin = 0; for (int i = 0; i < 4; i++) c_din[i] = '0; c_ordy = 1;

    // Test 1: streaming 0..7, ready high throughout
    for (int i = 0; i < 8; i++)
      add(1, 8'(i), 1, 1, (i == 4), (i == 4) ? W0123 : 32'h0);
    add(0, 8'h0, 1, 1, 1, W4567);
    add(0, 8'h0, 1, 1, 0, 32'h0);
    // Test 2: back-pressure after the first word
    for (int i = 0; i < 4; i++) add(1, 8'(i), 1, 1, 0, 32'h0);
    add(1, 8'd4, 0, 1, 1, W0123);
    add(1, 8'd5, 0, 1, 1, W0123);
    add(1, 8'd6, 0, 1, 1, W0123);
    add(1, 8'd7, 0, 0, 1, W0123);
    add(1, 8'd7, 0, 0, 1, W0123);
    add(1, 8'd7, 1, 1, 1, W0123);
    add(0, 8'd0, 1, 1, 1, W4567);
    add(0, 8'd0, 1, 1, 0, 32'h0);

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a_in_ready", 32'(a_irdy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_a_out_valid", 32'(a_ov), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("reset_a_data[%0d]", i), 32'(a_dout[i]), 32'd0);
    chk("reset_b_out_valid", 32'(b_ov), 32'd0);
    chk("reset_c_out_valid", 32'(c_ov), 32'd0);

    // Tests 1 and 2 from the vector table
    foreach (vt[n]) begin
      @(posedge clk); #1;
      a_vin = vt[n].vin; a_din[0] = vt[n].din; a_ordy = vt[n].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", n), 32'(a_irdy), 32'(vt[n].exp_irdy));
      chk($sformatf("vec%0d_out_valid", n), 32'(a_ov), 32'(vt[n].exp_ov));
      if (vt[n].exp_ov)
        for (int i = 0; i < 4; i++)
          chk($sformatf("vec%0d_data[%0d]", n, i), 32'(a_dout[i]), 32'(vt[n].exp_word[8*i +: 8]));
    end

    // Test 5: reset after two of four beats discards them
    @(posedge clk); #1 a_vin = 1; a_din[0] = 8'h50; a_ordy = 1;
    @(posedge clk); #1 a_din[0] = 8'h51;
    @(posedge clk); #1 a_vin = 0; rst = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", 32'(a_irdy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 32'(a_ov), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 a_vin = 1; a_din[0] = 8'(9 + i);
    end
    @(posedge clk); #1 a_vin = 0;
    @(negedge clk);
    chk("midreset_word_valid", 32'(a_ov), 32'd1);
    for (int i = 0; i < 4; i++) chk($sformatf("midreset_word[%0d]", i), 32'(a_dout[i]), 32'(9 + i));
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset_single_word", 32'(a_ov), 32'd0);

    // Test 3: 2->6 with random valid gaps; counter holds across gaps
    for (int k = 0; k < 3; k++) begin
      int gap;
      gap = $urandom_range(3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1 b_vin = 0;
        @(negedge clk);
        chk("gap_no_partial_flush", 32'(b_ov), 32'd0);
      end
      @(posedge clk); #1;
      b_vin = 1; b_din[0] = 8'(8'hA0 + 8'h10 * k); b_din[1] = 8'(8'hA1 + 8'h10 * k);
      exp6[2*k] = b_din[0]; exp6[2*k+1] = b_din[1];
      @(negedge clk);
      chk($sformatf("gap_beat%0d_ready", k), 32'(b_irdy), 32'd1);
    end
    @(posedge clk); #1 b_vin = 0;
    @(negedge clk);
    chk("gap_word_valid", 32'(b_ov), 32'd1);
    for (int i = 0; i < 6; i++) chk($sformatf("gap_word[%0d]", i), 32'(b_dout[i]), 32'(exp6[i]));

    // Test 4: BEATS==1 pass-through at one word per cycle, one cycle latency
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      c_vin = 1; c_ordy = 1;
      for (int i = 0; i < 4; i++) c_din[i] = 8'($urandom);
      @(negedge clk);
      chk($sformatf("thru%0d_ready", n), 32'(c_irdy), 32'd1);
      if (n > 0) begin
        chk($sformatf("thru%0d_valid", n), 32'(c_ov), 32'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("thru%0d_data[%0d]", n, i), 32'(c_dout[i]), 32'(prev[i]));
      end
      for (int i = 0; i < 4; i++) prev[i] = c_din[i];
    end
    @(posedge clk); #1 c_vin = 0;
    repeat (2) @(posedge clk);

    // Randomized handshakes on all three instances against the queue model
    wtgt[0] = 1000; wtgt[1] = 400; wtgt[2] = 600;
    tgt[0] = acc_beats[0] + wtgt[0] * 4;
    tgt[1] = acc_beats[1] + wtgt[1] * 3;
    tgt[2] = acc_beats[2] + wtgt[2] * 1;
    for (int i = 0; i < 3; i++) words_out[i] = 0;
    done = 0;
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      @(posedge clk); #1;
      a_vin = (acc_beats[0] < tgt[0]) && ($urandom_range(3) != 0);
      a_din[0] = 8'($urandom);
      a_ordy = ($urandom_range(2) != 0);
      b_vin = (acc_beats[1] < tgt[1]) && ($urandom_range(2) != 0);
      for (int i = 0; i < 2; i++) b_din[i] = 8'($urandom);
      b_ordy = ($urandom_range(3) != 0);
      c_vin = (acc_beats[2] < tgt[2]) && ($urandom_range(1) != 0);
      for (int i = 0; i < 4; i++) c_din[i] = 8'($urandom);
      c_ordy = ($urandom_range(1) != 0);
      done = (acc_beats[0] >= tgt[0]) && (acc_beats[1] >= tgt[1]) && (acc_beats[2] >= tgt[2]);
    end
    chk("random_completed_in_budget", 32'(done), 32'd1);
    @(posedge clk); #1;
    a_vin = 0; b_vin = 0; c_vin = 0; a_ordy = 1; b_ordy = 1; c_ordy = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("u%0d_no_drop_no_dup_words", id), 32'(words_out[id]), 32'(wtgt[id]));
      chk($sformatf("u%0d_model_drained", id), 32'(q[id].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
